// File: rtl/corelet_seq.sv
// corelet_seq: self-sequencing row x col MAC corelet.
// One start runs a full pass: load col weight beats, stream len activation
// beats into the MAC array, then drain the results through an optional psum
// accumulate and ReLU stage onto a valid/ready output port.
// Optional feature macro: CORELET_SEQ_RELU_EN (honour i_relu per pass).
module corelet_seq #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int max_len = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [$clog2(max_len+1)-1:0] i_len,
    input  logic                         i_acc,
    input  logic                         i_relu,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [row*bw-1:0]            i_in_d,
    input  logic                         i_psum_valid,
    output logic                         o_psum_ready,
    input  logic [col*psum_bw-1:0]       i_psum_in,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [col*psum_bw-1:0]       o_out_d,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int LW = $clog2(max_len + 1);
    localparam int AW = (max_len > 1) ? $clog2(max_len) : 1;
    localparam int CW = (col > 1) ? $clog2(col) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_EXEC, S_DRAIN, S_FIN} state_t;

    state_t                 r_state, w_next;
    logic [LW-1:0]          r_len;
    logic                   r_acc;
    logic                   r_fin_wait;   // len=0 pass: one extra FIN cycle before done
    logic [CW-1:0]          r_cnt;        // weight beat (column) index
    logic [LW-1:0]          r_push;       // activations issued == OFIFO writes
    logic [LW-1:0]          r_pop;        // OFIFO reads
    logic [LW-1:0]          r_hs;         // output handshakes
    logic [row*bw-1:0]      r_w [col];    // r_w[c] holds w[r][c] at element r
    logic [col*psum_bw-1:0] r_fifo [max_len];
    logic [col*psum_bw-1:0] r_out_d;
    logic                   r_out_valid;

    logic                   w_in_fire, w_last_w, w_last_x;
    logic                   w_fifo_ne, w_can, w_pop, w_out_fire, w_last_out;
    logic [col*psum_bw-1:0] w_mac, w_res;

`ifdef CORELET_SEQ_RELU_EN
    logic r_relu;
`else
    logic w_relu_unused;
    assign w_relu_unused = i_relu;
`endif

    function automatic logic [psum_bw-1:0] sext(input logic [bw-1:0] v);
        return {{(psum_bw-bw){v[bw-1]}}, v};
    endfunction

    function automatic logic [psum_bw-1:0] zext(input logic [bw-1:0] v);
        return {{(psum_bw-bw){1'b0}}, v};
    endfunction

    assign w_in_fire  = o_in_ready && i_in_valid;
    assign w_last_w   = (r_cnt == CW'(col - 1));
    assign w_last_x   = ((r_push + LW'(1)) == r_len);
    assign w_fifo_ne  = (r_pop != r_push);
    // A result may be formed when one is queued and the output slot frees up.
    assign w_can      = (r_state == S_DRAIN) && w_fifo_ne && (!r_out_valid || i_out_ready);
    assign w_pop      = w_can && (!r_acc || i_psum_valid);
    assign w_out_fire = r_out_valid && i_out_ready;
    assign w_last_out = w_out_fire && ((r_hs + LW'(1)) == r_len);
    assign o_out_valid = r_out_valid;
    assign o_out_d     = r_out_d;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = (i_len == '0) ? S_FIN : S_LOAD_W;
            S_LOAD_W: if (w_in_fire && w_last_w) w_next = S_EXEC;
            S_EXEC:   if (w_in_fire && w_last_x) w_next = S_DRAIN;
            S_DRAIN:  if (w_last_out) w_next = S_FIN;
            S_FIN:    if (!r_fin_wait) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        o_in_ready   = (r_state == S_LOAD_W) || (r_state == S_EXEC);
        o_psum_ready = w_can && r_acc;
        o_busy       = (r_state != S_IDLE);
        o_done       = (r_state == S_FIN) && !r_fin_wait;
    end

    // MAC array: one full result vector per activation beat.
    always_comb begin
        w_mac = '0;
        for (int c = 0; c < col; c++) begin
            logic [psum_bw-1:0] s;
            s = '0;
            for (int r = 0; r < row; r++)
                s = s + sext(r_w[c][r*bw +: bw]) * zext(i_in_d[r*bw +: bw]);
            w_mac[c*psum_bw +: psum_bw] = s;
        end
    end

    // SFP lanes: optional psum accumulate, then optional clamp at zero.
    always_comb begin
        w_res = '0;
        for (int c = 0; c < col; c++) begin
            logic [psum_bw-1:0] v;
            v = r_fifo[r_pop[AW-1:0]][c*psum_bw +: psum_bw]
              + (r_acc ? i_psum_in[c*psum_bw +: psum_bw] : '0);
`ifdef CORELET_SEQ_RELU_EN
            if (r_relu && v[psum_bw-1]) v = '0;
`endif
            w_res[c*psum_bw +: psum_bw] = v;
        end
    end

    // Weight and OFIFO storage; validity is tracked by the counters alone.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD_W && w_in_fire) r_w[r_cnt] <= i_in_d;
        if (r_state == S_EXEC && w_in_fire)   r_fifo[r_push[AW-1:0]] <= w_mac;
    end

    // Pass configuration, counters and the output register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len       <= '0;
            r_acc       <= 1'b0;
            r_fin_wait  <= 1'b0;
            r_cnt       <= '0;
            r_push      <= '0;
            r_pop       <= '0;
            r_hs        <= '0;
            r_out_d     <= '0;
            r_out_valid <= 1'b0;
`ifdef CORELET_SEQ_RELU_EN
            r_relu      <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_len      <= i_len;
                r_acc      <= i_acc;
                r_fin_wait <= (i_len == '0);
                r_cnt      <= '0;
                r_push     <= '0;
                r_pop      <= '0;
                r_hs       <= '0;
`ifdef CORELET_SEQ_RELU_EN
                r_relu     <= i_relu;
`endif
            end
            if (r_state == S_FIN) r_fin_wait <= 1'b0;
            if (r_state == S_LOAD_W && w_in_fire) r_cnt <= r_cnt + CW'(1);
            if (r_state == S_EXEC && w_in_fire)   r_push <= r_push + LW'(1);
            if (w_pop)      r_pop <= r_pop + LW'(1);
            if (w_out_fire) r_hs <= r_hs + LW'(1);
            if (w_pop) begin
                r_out_d     <= w_res;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: directed passes push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_corelet_seq;

    localparam int BW = 4, PW = 16, ROW = 8, COL = 8, ML = 16;
    localparam int LW = $clog2(ML + 1);

    logic              clk = 0;
    logic              i_reset = 1, i_start = 0, i_acc = 0, i_relu = 0;
    logic [LW-1:0]     i_len = '0;
    logic              i_in_valid = 0, i_psum_valid = 0, i_out_ready = 1;
    logic [ROW*BW-1:0] i_in_d = '0;
    logic [COL*PW-1:0] i_psum_in = '0;
    logic              o_in_ready, o_psum_ready, o_out_valid, o_busy, o_done;
    logic [COL*PW-1:0] o_out_d;

    corelet_seq #(.bw(BW), .psum_bw(PW), .row(ROW), .col(COL), .max_len(ML)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
        .i_acc(i_acc), .i_relu(i_relu), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_d(i_in_d), .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
        .i_psum_in(i_psum_in), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_d(o_out_d), .o_busy(o_busy), .o_done(o_done));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, last_hs_cyc = 0, done_cnt = 0;
    logic [COL*PW-1:0] exp_q[$], psum_q[$];
    logic [ROW*BW-1:0] wbeats [COL];
    logic [ROW*BW-1:0] acts[$];
    bit rdy_toggle = 0, rdy_val = 1, psum_hold = 0;

    task automatic check(input string name, input logic [COL*PW-1:0] act, input logic [COL*PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [ROW*BW-1:0] xall(input int v);
        logic [ROW*BW-1:0] d;
        for (int r = 0; r < ROW; r++) d[r*BW +: BW] = BW'(v);
        return d;
    endfunction

    function automatic logic [COL*PW-1:0] yall(input int v);
        logic [COL*PW-1:0] d;
        for (int c = 0; c < COL; c++) d[c*PW +: PW] = PW'(v);
        return d;
    endfunction

    task automatic set_identity();
        for (int c = 0; c < COL; c++) begin
            wbeats[c] = '0;
            wbeats[c][c*BW +: BW] = BW'(1);
        end
    endtask

    task automatic set_allw(input int v);
        for (int c = 0; c < COL; c++) wbeats[c] = xall(v);
    endtask

    always @(posedge clk) cyc++;
    always @(negedge clk) if (o_done) done_cnt++;

    // Output ready driver (steady or toggling every cycle).
    always @(posedge clk) begin
        #1;
        i_out_ready = rdy_toggle ? ~i_out_ready : rdy_val;
    end

    // Psum source: present the queue head, pop on handshake.
    initial begin
        bit pfire;
        forever begin
            @(negedge clk);
            pfire = i_psum_valid && o_psum_ready;
            @(posedge clk);
            #1;
            if (pfire) void'(psum_q.pop_front());
            i_psum_valid = (psum_q.size() != 0) && !psum_hold;
            if (psum_q.size() != 0) i_psum_in = psum_q[0];
        end
    end

    // Monitor: compare every output handshake against the scoreboard.
    initial begin
        bit stall_prev = 0;
        logic [COL*PW-1:0] prev_d = '0;
        forever begin
            @(negedge clk);
            if (stall_prev && !i_reset) begin
                check("hold_valid", COL*PW'(o_out_valid), COL*PW'(1));
                check("hold_data", o_out_d, prev_d);
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out got %h want none", o_out_d);
                end else begin
                    check("result", o_out_d, exp_q.pop_front());
                end
                last_hs_cyc = cyc;
            end
            stall_prev = o_out_valid && !i_out_ready && !i_reset;
            prev_d = o_out_d;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, COL*PW'(o_in_ready), '0);
        check({tag, "_psum_ready"}, COL*PW'(o_psum_ready), '0);
        check({tag, "_out_valid"}, COL*PW'(o_out_valid), '0);
        check({tag, "_out_d"}, o_out_d, '0);
        check({tag, "_busy"}, COL*PW'(o_busy), '0);
        check({tag, "_done"}, COL*PW'(o_done), '0);
    endtask

    // Called at posedge+1; leaves at posedge+1 after the accepting edge.
    task automatic start_pass(input int len, input bit acc, input bit relu);
        i_start = 1; i_len = LW'(len); i_acc = acc; i_relu = relu;
        @(posedge clk); #1;
        i_start = 0;
        if (len > 0) begin
            @(negedge clk);
            check("in_ready_rise", COL*PW'(o_in_ready), COL*PW'(1));
            check("busy_rise", COL*PW'(o_busy), COL*PW'(1));
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [ROW*BW-1:0] d, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        i_in_d = d; i_in_valid = 1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (o_in_ready) ok = 1;
            @(posedge clk); #1;
        end
        i_in_valid = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL in_timeout got no in_ready want in_ready");
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1;
                check({tag, "_done_after_hs"}, COL*PW'(cyc - last_hs_cyc), COL*PW'(1));
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout got no done want done", tag);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, COL*PW'(o_done), '0);
        check({tag, "_busy_fall"}, COL*PW'(o_busy), '0);
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input string tag, input int len, input bit acc, input bit relu, input int gapmod);
        start_pass(len, acc, relu);
        for (int c = 0; c < COL; c++) send(wbeats[c], 0);
        for (int k = 0; k < len; k++) send(acts[k], (gapmod > 0) ? (k % gapmod) : 0);
        wait_done(tag);
        acts.delete();
    endtask

    initial begin
        logic [ROW*BW-1:0] xv;
        logic [COL*PW-1:0] yv;
        int d0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        i_reset = 0;
        @(posedge clk); #1;

        // Identity weights, three vectors
        set_identity();
        for (int r = 0; r < ROW; r++) xv[r*BW +: BW] = BW'(r + 1);
        for (int c = 0; c < COL; c++) yv[c*PW +: PW] = PW'(c + 1);
        acts.push_back(xv); acts.push_back(xall(15)); acts.push_back(xall(0));
        exp_q.push_back(yv); exp_q.push_back(yall(15)); exp_q.push_back(yall(0));
        run_pass("ident", 3, 0, 0, 0);

        // All weights -1, x=15, psum 200 -> 80
        set_allw(15);
        acts.push_back(xall(15)); psum_q.push_back(yall(200)); exp_q.push_back(yall(80));
        run_pass("acc", 1, 1, 0, 0);

        // Same with relu and psum 0
        acts.push_back(xall(15)); psum_q.push_back(yall(0));
`ifdef CORELET_SEQ_RELU_EN
        exp_q.push_back(yall(0));
`else
        exp_q.push_back(yall(-120));
`endif
        run_pass("relu", 1, 1, 1, 0);

        // len=16 with out_ready toggling and input bubbles
        set_identity();
        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < ROW; r++) xv[r*BW +: BW] = BW'((k + r) % 16);
            for (int c = 0; c < COL; c++) yv[c*PW +: PW] = PW'((k + c) % 16);
            acts.push_back(xv); exp_q.push_back(yv);
        end
        rdy_toggle = 1;
        run_pass("toggle", 16, 0, 0, 2);
        rdy_toggle = 0; rdy_val = 1;
        @(posedge clk); #1;

        // Psum withheld for 10 cycles: no output meanwhile
        psum_hold = 1;
        psum_q.push_back(yall(10)); psum_q.push_back(yall(5));
        exp_q.push_back(yall(13)); exp_q.push_back(yall(8));
        start_pass(2, 1, 0);
        for (int c = 0; c < COL; c++) send(wbeats[c], 0);
        send(xall(3), 0); send(xall(3), 0);
        repeat (10) begin
            @(negedge clk);
            check("psum_stall", COL*PW'(o_out_valid), '0);
        end
        @(posedge clk); #1;
        psum_hold = 0;
        wait_done("psumhold");

        // Wrap: 32767 + 7 -> -32762
        acts.push_back(xall(7)); psum_q.push_back(yall(32767)); exp_q.push_back(yall(-32762));
        run_pass("wrap", 1, 1, 0, 0);

        // Reset mid-EXEC, then a clean pass
        set_allw(15);
        start_pass(3, 0, 0);
        for (int c = 0; c < COL; c++) send(wbeats[c], 0);
        send(xall(2), 0);
        i_reset = 1;
        @(posedge clk);
        @(negedge clk);
        check_idle("midreset");
        i_reset = 0;
        @(posedge clk); #1;
        acts.push_back(xall(1)); exp_q.push_back(yall(-8));
        run_pass("fresh", 1, 0, 0, 0);

        // len=0: done two cycles after start, no data movement
        d0 = done_cnt;
        start_pass(0, 0, 0);
        @(negedge clk);
        check("len0_done_early", COL*PW'(o_done), '0);
        check("len0_busy", COL*PW'(o_busy), COL*PW'(1));
        check("len0_in_ready", COL*PW'(o_in_ready), '0);
        @(negedge clk);
        check("len0_done", COL*PW'(o_done), COL*PW'(1));
        @(negedge clk);
        check("len0_idle", COL*PW'(o_busy), '0);
        check("len0_pulses", COL*PW'(done_cnt - d0), COL*PW'(1));
        @(posedge clk); #1;

        // start pulsed while busy is ignored
        set_identity();
        d0 = done_cnt;
        for (int r = 0; r < ROW; r++) xv[r*BW +: BW] = BW'(r + 1);
        for (int c = 0; c < COL; c++) yv[c*PW +: PW] = PW'(c + 1);
        exp_q.push_back(yv);
        start_pass(1, 0, 0);
        send(wbeats[0], 0);
        i_start = 1; i_len = LW'(2);
        send(wbeats[1], 0);
        i_start = 0;
        for (int c = 2; c < COL; c++) send(wbeats[c], 0);
        send(xv, 0);
        wait_done("busystart");
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busystart_pulses", COL*PW'(done_cnt - d0), COL*PW'(1));
        check("busystart_idle", COL*PW'(o_busy), '0);

        check("scoreboard_empty", COL*PW'(exp_q.size()), '0);
        check("psum_consumed", COL*PW'(psum_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/corelet_seq.md
# corelet_seq

Self-sequencing, parametrised successor of the row×col compute corelet: it wraps the L0 input buffer, MAC array, output FIFO and per-column SFP lanes behind an internal control FSM, so the host no longer drives raw `in_ctrl` bits. One `start` runs a complete pass:

- load col weight vectors;
- stream `len` activation vectors;
- optionally accumulate an external partial sum per result;
- hand each result out over a valid/ready port.

It sits between the activation/weight memory and the psum memory in the core.

## Interface
- `bw`, 4, activation/weight element width
- `psum_bw`, 16, partial-sum width
- `row`, 8, array rows (elements per input vector)
- `col`, 8, array columns (elements per result vector)
- `max_len`, 16, max activation vectors per pass; internal OFIFO depth ≥ `max_len`
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: pass request, sampled only in IDLE
- `len` in $clog2(max_len+1): activation vectors this pass, latched on start
- `acc` in 1: add `psum_in` to each result, latched on start
- `relu` in 1: clamp results at 0, latched on start
- `in_valid` in 1 / `in_ready` out 1 / `in_d` in row*bw: weight then activation stream
- `psum_valid` in 1 / `psum_ready` out 1 / `psum_in` in col*psum_bw: partial-sum stream
- `out_valid` out 1 / `out_ready` in 1 / `out_d` out col*psum_bw: result stream
- `busy` out 1: pass in progress
- `done` out 1: one-cycle pulse at pass end

## Operation
- **FSM: IDLE → LOAD_W → EXEC → DRAIN → FIN → IDLE.**
  - IDLE: `start`=1 and `len`≠0 latches `len`/`acc`/`relu`, clears the SFP accumulators and moves to LOAD_W.
  - `start` with `len`=0 goes to FIN directly; no data moves.
  - LOAD_W: accepts exactly `col` beats. Beat c carries w[r][c] at element r, and each is issued to the array as a kernel load. Then → EXEC.
  - EXEC: accepts exactly `len` activation beats, each issued as an execute. Then → DRAIN.
  - DRAIN: pops OFIFO results in order and emits `len` results. Then → FIN.
  - FIN: pulses `done` for one cycle, then → IDLE.
- **Result k:** y[k][c] = Σ_r w[r][c]·x[k][r].
  - w is signed `bw` bits, x is unsigned `bw` bits.
  - The sum is signed `psum_bw` bits and wraps modulo 2^psum_bw.
  - If `acc`: y += `psum_in` lane c of the k-th psum beat, also wrapping.
  - If `relu` (see Configuration): a negative y becomes 0 after accumulation.
- **Psum handshake:** exactly one psum beat is consumed per result when `acc`=1. `psum_ready` is asserted only in DRAIN with `acc`=1. No psum beats are consumed when `acc`=0.
- **Input handshake:** a beat transfers when `in_valid`&`in_ready`. `in_ready`=1 only in LOAD_W/EXEC. Gaps in `in_valid` insert bubbles (the array sees no-op) without corrupting results.
- **Output backpressure:** `out_d`/`out_valid` hold stable while `out_ready`=0. DRAIN stalls, including OFIFO pops and psum consumption, and no result is lost or duplicated.
- **Control priority:**
  - `start` while `busy` is ignored.
  - `reset` mid-pass returns to IDLE, drops all buffered data and zeroes all outputs.
  - OFIFO never overflows because `len` ≤ `max_len`.

## Timing
- Reset values: `in_ready`, `psum_ready`, `out_valid`, `busy`, `done` = 0; `out_d` = 0.
- `busy` rises the cycle after start is accepted and falls the cycle after the `done` pulse.
- `in_ready` rises the cycle after start is accepted.
- First `out_valid` occurs ≤ row+col+4 cycles after the last activation handshake, given `psum_valid`=1 when `acc`=1.
- With `out_ready`=1 and psum available, results are emitted one per cycle.
- `done` is asserted the cycle after the final output handshake.
- With `len`=0, `done` is asserted 2 cycles after start.
- `out_valid` deasserts after the last result; `out_d` holds its last value until the next pass.

## Configuration
- `CORELET_SEQ_RELU_EN`:
  - **Defined:** the `relu` input is honoured per pass.
  - **Undefined:** `relu` is ignored, the clamp logic is not compiled, and results pass signed.

## Test plan
- Identity weights (w[r][c]=1 if r==c), `len`=3, x=[1..8],[15×8],[0×8], `acc`=0, `out_ready`=1 → out = [1..8], [15×8], [0×8]; `done` follows the third result; `busy` drops after it.
- All weights −1, x all 15, `acc`=1, psum all 200 → every lane = 80; with `relu`=1 and psum 0 → every lane = 0 (macro defined) / −120 (undefined).
- Toggle `out_ready` 1/0 every cycle with `len`=16 → exactly 16 results in order, values unchanged.
- Hold `psum_valid`=0 for 10 cycles → `out_valid` stays 0 during that time.
- Wrap check: `psum_bw`=16, acc psum 32767 plus product sum 7 → lane reads −32762.
- Assert `reset` mid-EXEC → next cycle all outputs 0 and in IDLE; a fresh pass with `len`=1 gives the correct result with no stale data.
- `start` with `len`=0 → `done` pulse 2 cycles later with no in/out handshakes.
- `start` pulsed while `busy` → ignored; pass count unchanged.
